// File: rtl/pc_branch_ctrl.sv
// Program counter with jump resolution, one-cycle flush bubble after taken branches,
// stall, sticky halt and a saturating taken-branch counter.
module pc_branch_ctrl #(
   parameter int PC_WIDTH  = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stall,
   input  logic                 haltReq,
   input  logic                 jmp,
   input  logic                 jmpZ,
   input  logic                 jmpNZ,
   input  logic [PC_WIDTH-1:0]  target,
   input  logic                 Zflag,
   output logic [PC_WIDTH-1:0]  pc,
   output logic                 pcValid,
   output logic                 flush,
   output logic                 branchTaken,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] takenCount
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      BUBBLE = 2'd2,
      HALT   = 2'd3
   } state_t;

   state_t               stateQ, stateD;
   logic [PC_WIDTH-1:0]  pcQ, pcD;
   logic [CNT_WIDTH-1:0] cntQ, cntD;
   logic                 taken;

   assign taken = jmp | (jmpZ & Zflag) | (jmpNZ & ~Zflag);

   always_comb begin
      stateD = stateQ;
      pcD    = pcQ;
      cntD   = cntQ;
      unique case (stateQ)
         IDLE: begin
            if (start) stateD = RUN;
         end
         RUN: begin
            // Halt outranks stall; a stalled cycle drops jump requests entirely.
            if (haltReq) begin
               stateD = HALT;
            end else if (stall) begin
               stateD = RUN;
            end else if (taken) begin
               pcD    = target;
               stateD = BUBBLE;
               if (cntQ != '1) cntD = cntQ + CNT_WIDTH'(1);
            end else begin
               pcD = pcQ + PC_WIDTH'(1);
            end
         end
         BUBBLE: begin
            stateD = haltReq ? HALT : RUN;
         end
         HALT: begin
            stateD = HALT;
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= IDLE;
         pcQ    <= '0;
         cntQ   <= '0;
      end else begin
         stateQ <= stateD;
         pcQ    <= pcD;
         cntQ   <= cntD;
      end
   end

   // Status outputs are pure state decodes, so nothing combinational leaks from the inputs.
   assign pc          = pcQ;
   assign takenCount  = cntQ;
   assign pcValid     = (stateQ == RUN);
   assign flush       = (stateQ == BUBBLE);
   assign branchTaken = (stateQ == BUBBLE);
   assign halted      = (stateQ == HALT);

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed-vector bench for pc_branch_ctrl; a second instance with a 2-bit counter
// shares every input and exercises counter saturation.
module tb_pc_branch_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stall;
   logic       haltReq;
   logic       jmp;
   logic       jmpZ;
   logic       jmpNZ;
   logic [7:0] target;
   logic       Zflag;

   logic [7:0] pc, pcS;
   logic       pcValid, pcValidS;
   logic       flush, flushS;
   logic       branchTaken, branchTakenS;
   logic       halted, haltedS;
   logic [7:0] takenCount;
   logic [1:0] takenCountS;

   int vectors = 0;
   int errors  = 0;
   int expCnt  = 0;

   pc_branch_ctrl #(.PC_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall), .haltReq(haltReq),
      .jmp(jmp), .jmpZ(jmpZ), .jmpNZ(jmpNZ), .target(target), .Zflag(Zflag),
      .pc(pc), .pcValid(pcValid), .flush(flush), .branchTaken(branchTaken),
      .halted(halted), .takenCount(takenCount)
   );

   pc_branch_ctrl #(.PC_WIDTH(8), .CNT_WIDTH(2)) dutSat (
      .clk(clk), .rst(rst), .start(start), .stall(stall), .haltReq(haltReq),
      .jmp(jmp), .jmpZ(jmpZ), .jmpNZ(jmpNZ), .target(target), .Zflag(Zflag),
      .pc(pcS), .pcValid(pcValidS), .flush(flushS), .branchTaken(branchTakenS),
      .halted(haltedS), .takenCount(takenCountS)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One clock edge, then settle before the caller samples.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkState(input string tag, input logic [7:0] expPc, input logic expValid,
                             input logic expFlush, input logic expHalted);
      checkOutput({tag, ".pc"}, {24'd0, pc}, {24'd0, expPc});
      checkOutput({tag, ".pcValid"}, {31'd0, pcValid}, {31'd0, expValid});
      checkOutput({tag, ".flush"}, {31'd0, flush}, {31'd0, expFlush});
      checkOutput({tag, ".branchTaken"}, {31'd0, branchTaken}, {31'd0, expFlush});
      checkOutput({tag, ".halted"}, {31'd0, halted}, {31'd0, expHalted});
      checkOutput({tag, ".takenCount"}, {24'd0, takenCount}, expCnt);
   endtask

   task automatic clearInputs();
      start = 0; stall = 0; haltReq = 0; jmp = 0; jmpZ = 0; jmpNZ = 0; Zflag = 0; target = 8'h00;
   endtask

   // Taken unconditional jump followed by the bubble cycle, leaving the block in RUN at dest.
   task automatic jumpTo(input logic [7:0] dest);
      jmp = 1; target = dest;
      applyStimulus();
      expCnt++;
      checkState("jumpBubble", dest, 0, 1, 0);
      jmp = 0;
      applyStimulus();
      checkState("jumpLand", dest, 1, 0, 0);
   endtask

   initial begin
      logic [1:0] satExp [5];
      satExp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      clearInputs();
      rst = 1;
      applyStimulus();
      applyStimulus();
      checkState("reset", 8'h00, 0, 0, 0);

      rst = 0; haltReq = 1;
      applyStimulus();
      checkState("idleIgnoresHalt", 8'h00, 0, 0, 0);
      haltReq = 0; start = 1;
      applyStimulus();
      checkState("start", 8'h00, 1, 0, 0);
      start = 0;
      for (int i = 1; i <= 5; i++) begin
         applyStimulus();
         checkState("seq", 8'(i), 1, 0, 0);
      end

      jmpZ = 1; Zflag = 1; target = 8'h40;
      applyStimulus();
      expCnt++;
      checkState("jmpZTaken", 8'h40, 0, 1, 0);
      checkOutput("jmpZTaken.satCount", {30'd0, takenCountS}, 32'd1);
      clearInputs();
      applyStimulus();
      checkState("jmpZLand", 8'h40, 1, 0, 0);

      jumpTo(8'h05);
      jmpZ = 1; Zflag = 0; target = 8'h40;
      applyStimulus();
      checkState("jmpZNotTaken", 8'h06, 1, 0, 0);
      clearInputs();

      jmpNZ = 1; Zflag = 0; target = 8'h40;
      applyStimulus();
      expCnt++;
      checkState("jmpNZTaken", 8'h40, 0, 1, 0);
      clearInputs();
      applyStimulus();
      checkState("jmpNZLand", 8'h40, 1, 0, 0);

      jmpZ = 1; jmpNZ = 1; Zflag = 1; target = 8'h22;
      applyStimulus();
      expCnt++;
      checkState("bothCond", 8'h22, 0, 1, 0);
      clearInputs();
      applyStimulus();

      jumpTo(8'h0A);
      stall = 1; jmp = 1; target = 8'h80;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkState("stall", 8'h0A, 1, 0, 0);
      end
      stall = 0;
      applyStimulus();
      expCnt++;
      checkState("stallRelease", 8'h80, 0, 1, 0);
      jmp = 0;
      applyStimulus();
      checkState("stallLand", 8'h80, 1, 0, 0);

      jumpTo(8'h80);

      jumpTo(8'hFE);
      applyStimulus();
      checkState("wrapFF", 8'hFF, 1, 0, 0);
      applyStimulus();
      checkState("wrap00", 8'h00, 1, 0, 0);
      applyStimulus();
      checkState("wrap01", 8'h01, 1, 0, 0);

      jumpTo(8'h07);
      haltReq = 1;
      applyStimulus();
      checkState("halt", 8'h07, 0, 0, 1);
      haltReq = 0; start = 1; jmp = 1; target = 8'h33;
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         checkState("haltSticky", 8'h07, 0, 0, 1);
      end
      clearInputs();

      rst = 1;
      applyStimulus();
      expCnt = 0;
      checkState("resetFromHalt", 8'h00, 0, 0, 0);
      rst = 0;

      start = 1;
      applyStimulus();
      start = 0;
      jmp = 1; target = 8'h20;
      applyStimulus();
      expCnt++;
      checkState("bubbleHaltPre", 8'h20, 0, 1, 0);
      jmp = 0; haltReq = 1;
      applyStimulus();
      checkState("bubbleHalt", 8'h20, 0, 0, 1);
      haltReq = 0;

      rst = 1;
      applyStimulus();
      expCnt = 0;
      rst = 0; start = 1;
      applyStimulus();
      start = 0;
      for (int i = 0; i < 5; i++) begin
         jmp = 1; target = 8'(8'h10 + i);
         applyStimulus();
         expCnt++;
         checkOutput("satCount", {30'd0, takenCountS}, {30'd0, satExp[i]});
         checkOutput("satMainCount", {24'd0, takenCount}, expCnt);
         jmp = 0;
         applyStimulus();
      end

      jmp = 1; target = 8'h55;
      applyStimulus();
      expCnt++;
      checkState("preResetBubble", 8'h55, 0, 1, 0);
      jmp = 0; rst = 1;
      applyStimulus();
      expCnt = 0;
      checkState("resetInBubble", 8'h00, 0, 0, 0);
      checkOutput("resetInBubble.satCount", {30'd0, takenCountS}, 32'd0);
      rst = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
- Program-counter and branch-resolution block for one core; it is the consumer of the zero flag produced by each core's Z register.
- Holds the PC and advances it sequentially.
- Resolves unconditional and Z-conditional jumps, inserts a one-cycle flush bubble after every taken branch, and supports stall and halt.
- Sits between the core's control unit (jump requests) and the instruction-memory address port.

Parameters:
- PC_WIDTH, 8, width of program counter and jump target.
- CNT_WIDTH, 8, width of the taken-branch counter (saturating).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  leave IDLE and begin fetching at PC 0.
- stall  input  1  freeze PC and all state except the halt path.
- haltReq  input  1  enter HALT.
- jmp  input  1  unconditional jump request.
- jmpZ  input  1  jump if Zflag=1.
- jmpNZ  input  1  jump if Zflag=0.
- target  input  PC_WIDTH  jump destination.
- Zflag  input  1  registered zero flag from the core's Z register, used as-is in the cycle a conditional request is high.
- pc  output  PC_WIDTH  current program counter (registered).
- pcValid  output  1  pc is a valid fetch address this cycle.
- flush  output  1  discard the instruction fetched in the previous cycle.
- branchTaken  output  1  one-cycle pulse, concurrent with flush.
- halted  output  1  block is in HALT.
- takenCount  output  CNT_WIDTH  number of taken branches, saturating.

Behaviour:
- Reset (rst=1 at a clk edge, any state, overrides every other input): state=IDLE, pc=0, pcValid=0, flush=0, branchTaken=0, halted=0, takenCount=0.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- States: IDLE, RUN, BUBBLE, HALT.
  - pcValid=1 only in RUN.
  - flush=branchTaken=1 only in BUBBLE.
  - halted=1 only in HALT.
- IDLE:
  - start=1 -> RUN next cycle, pc stays 0.
  - All other inputs are ignored, haltReq included.
- RUN, evaluated each edge in priority order:
  - haltReq=1 -> HALT; pc held.
  - Else stall=1 -> remain in RUN; pc held; jump requests are ignored (the control unit must hold them).
  - Else taken = jmp | (jmpZ & Zflag) | (jmpNZ & ~Zflag). If taken: pc<=target, state->BUBBLE, takenCount<=takenCount+1 (saturates at 2^CNT_WIDTH-1).
  - Else pc<=pc+1, modulo 2^PC_WIDTH: from all-ones it wraps to 0 with no flag.
  - Several jump requests at once: the OR above applies. jmp dominates; jmpZ and jmpNZ together is always taken.
  - A jump to target==pc is legal and is still taken (bubble plus count).
- BUBBLE:
  - Lasts exactly one cycle; stall and jump inputs are ignored.
  - Next state: HALT if haltReq=1, else RUN.
  - pc holds target, so the first valid fetch after a branch is target.
- HALT:
  - pc and takenCount frozen; sticky until rst; start is ignored.
- Latency: a taken request at edge N gives pc=target at N+1 (BUBBLE, pcValid=0) and pcValid=1 at N+2. A not-taken request gives pc+1 at N+1 with pcValid=1.
- Zflag timing: the flag is sampled at the same edge as the jump request. The block does no internal flag forwarding.

Test Plan:
- Reset then start: rst=1 for 2 cycles, start=1 for 1 cycle -> pc=0, pcValid=1 on the cycle after start; with no other inputs pc reads 0,1,2,3,... one per cycle.
- Conditional jumps, PC_WIDTH=8:
  - At pc=5, jmpZ=1, Zflag=1, target=0x40 -> next cycle pc=0x40, flush=1, branchTaken=1, pcValid=0; following cycle pcValid=1, pc=0x40; takenCount=1.
  - At pc=5, jmpZ=1, Zflag=0 -> pc=6, no flush, takenCount unchanged.
  - jmpNZ with Zflag=0 -> taken, same response as the taken jmpZ case.
- Stall:
  - At pc=10, stall=1 for 3 cycles with jmp=1 and target=0x80 -> pc stays 10, no flush.
  - On the first cycle stall drops (jmp still 1) -> pc=0x80 with BUBBLE.
- Wrap: run from pc=0xFE -> pc sequence 0xFE, 0xFF, 0x00, 0x01 with pcValid continuously 1.
- Halt:
  - haltReq during RUN at pc=7 -> halted=1 next cycle, pc=7, pcValid=0; start and jmp then ignored for 5 cycles.
  - rst=1 -> all outputs return to reset values.
  - haltReq asserted in BUBBLE -> HALT directly after the bubble.
- Counter saturation and mid-operation reset:
  - CNT_WIDTH=2, 5 taken jmps -> takenCount reads 1, 2, 3, 3, 3.
  - rst asserted during BUBBLE -> IDLE, pc=0, flush=0 on the next cycle.
